// File: rtl/binary_to_bcd_seq_pkg.sv
// Shared types, constants and sizing helper for the binary-to-BCD converter family.
package bin_conv_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  localparam logic [1:0] ST_IDLE  = S_IDLE;
  localparam logic [1:0] ST_SHIFT = S_SHIFT;
  localparam logic [1:0] ST_DONE  = S_DONE;

  localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
  localparam logic [3:0] BCD_ADJ_ADD    = 4'd3;

  // ceil(width * log10(2)) in fixed point: decimal digits needed for 2^width-1.
  function automatic int clog10_digits(input int width);
    return (width * 30103 + 99999) / 100000;
  endfunction

endpackage

// File: rtl/binary_to_bcd_seq_digit_adj.sv
// Double-dabble digit correction: a digit of 5 or more gets +3 before the next shift.
module bcd_digit_adj
  import bin_conv_pkg::*;
(
  input  logic [3:0] i_digit,
  output logic [3:0] o_digit
);

  assign o_digit = (i_digit >= BCD_ADJ_THRESH) ? (i_digit + BCD_ADJ_ADD) : i_digit;

endmodule

// File: rtl/binary_to_bcd_seq.sv
// Sequential double-dabble converter, one operand bit per clock, with start/busy/done
// handshake plus hex and octal views of the captured operand.
module binary_to_bcd_seq
  import bin_conv_pkg::*;
#(
  parameter  int WIDTH  = 8,
  parameter  int DIGITS = clog10_digits(WIDTH),
  localparam int HEXW   = 4 * ((WIDTH + 3) / 4),
  localparam int OCTW   = 3 * ((WIDTH + 2) / 3)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [WIDTH-1:0]      i_bin_in,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [4*DIGITS-1:0]   o_bcd_out,
  output logic                  o_overflow,
  output logic [HEXW-1:0]       o_hex_out,
  output logic [OCTW-1:0]       o_oct_out
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [1:0]          r_state;
  logic [WIDTH-1:0]    r_shift;
  logic [4*DIGITS-1:0] r_scratch;
  logic [CW-1:0]       r_count;
  logic                r_ovf_acc;
  logic                r_busy;
  logic                r_done;
  logic [4*DIGITS-1:0] r_bcd;
  logic                r_ovf;
  logic [HEXW-1:0]     r_hex;
  logic [OCTW-1:0]     r_oct;

  logic [4*DIGITS-1:0] w_adj;
  logic [4*DIGITS-1:0] w_scratch_next;
  logic                w_lost;

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
    bcd_digit_adj u_adj (
      .i_digit (r_scratch[4*gi +: 4]),
      .o_digit (w_adj[4*gi +: 4])
    );
  end

  // Bit leaving the top digit is lost; it only matters when DIGITS is undersized.
  assign w_scratch_next = {w_adj[4*DIGITS-2:0], r_shift[WIDTH-1]};
  assign w_lost         = w_adj[4*DIGITS-1];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= ST_IDLE;
      r_shift   <= '0;
      r_scratch <= '0;
      r_count   <= '0;
      r_ovf_acc <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_bcd     <= '0;
      r_ovf     <= 1'b0;
      r_hex     <= '0;
      r_oct     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_shift   <= i_bin_in;
            r_scratch <= '0;
            r_count   <= CW'(WIDTH);
            r_ovf_acc <= 1'b0;
            r_hex     <= HEXW'(i_bin_in);
            r_oct     <= OCTW'(i_bin_in);
            r_busy    <= 1'b1;
            r_state   <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          r_scratch <= w_scratch_next;
          r_shift   <= {r_shift[WIDTH-2:0], 1'b0};
          r_ovf_acc <= r_ovf_acc | w_lost;
          r_count   <= r_count - CW'(1);
          if (r_count == CW'(1)) begin
            r_bcd   <= w_scratch_next;
            r_ovf   <= r_ovf_acc | w_lost;
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_bcd_out  = r_bcd;
  assign o_overflow = r_ovf;
  assign o_hex_out  = r_hex;
  assign o_oct_out  = r_oct;

endmodule

// File: tb/tb_binary_to_bcd_seq.sv
// Checks three converter configurations (8/3, 16/5, 8/2) against a decimal reference model.
module tb_binary_to_bcd_seq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        start0, start1, start2;
  logic [7:0]  bin0, bin2;
  logic [15:0] bin1;

  logic        busy0, busy1, busy2, done0, done1, done2, ovf0, ovf1, ovf2;
  logic [11:0] bcd0;
  logic [19:0] bcd1;
  logic [7:0]  bcd2;
  logic [7:0]  hex0, hex2;
  logic [15:0] hex1;
  logic [8:0]  oct0, oct2;
  logic [17:0] oct1;

  binary_to_bcd_seq #(.WIDTH(8), .DIGITS(3)) u_dut0 (
    .i_clk(clk), .i_rst(rst), .i_start(start0), .i_bin_in(bin0),
    .o_busy(busy0), .o_done(done0), .o_bcd_out(bcd0), .o_overflow(ovf0),
    .o_hex_out(hex0), .o_oct_out(oct0));

  binary_to_bcd_seq #(.WIDTH(16), .DIGITS(5)) u_dut1 (
    .i_clk(clk), .i_rst(rst), .i_start(start1), .i_bin_in(bin1),
    .o_busy(busy1), .o_done(done1), .o_bcd_out(bcd1), .o_overflow(ovf1),
    .o_hex_out(hex1), .o_oct_out(oct1));

  binary_to_bcd_seq #(.WIDTH(8), .DIGITS(2)) u_dut2 (
    .i_clk(clk), .i_rst(rst), .i_start(start2), .i_bin_in(bin2),
    .o_busy(busy2), .o_done(done2), .o_bcd_out(bcd2), .o_overflow(ovf2),
    .o_hex_out(hex2), .o_oct_out(oct2));

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int width_of(input int sel);
    return (sel == 1) ? 16 : 8;
  endfunction

  function automatic int digits_of(input int sel);
    return (sel == 0) ? 3 : (sel == 1) ? 5 : 2;
  endfunction

  // Reference: decimal digits of v modulo 10^digits, packed four bits per digit.
  function automatic logic [31:0] ref_bcd(input int unsigned v, input int digits);
    logic [31:0] r = 0;
    int unsigned x = v;
    for (int i = 0; i < digits; i++) begin
      r = r | (32'(x % 10) << (4 * i));
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [31:0] ref_ovf(input int unsigned v, input int digits);
    int unsigned lim = 1;
    for (int i = 0; i < digits; i++) lim = lim * 10;
    return (v >= lim) ? 32'd1 : 32'd0;
  endfunction

  function automatic logic [31:0] get_busy(input int sel);
    return (sel == 0) ? 32'(busy0) : (sel == 1) ? 32'(busy1) : 32'(busy2);
  endfunction
  function automatic logic [31:0] get_done(input int sel);
    return (sel == 0) ? 32'(done0) : (sel == 1) ? 32'(done1) : 32'(done2);
  endfunction
  function automatic logic [31:0] get_bcd(input int sel);
    return (sel == 0) ? 32'(bcd0) : (sel == 1) ? 32'(bcd1) : 32'(bcd2);
  endfunction
  function automatic logic [31:0] get_ovf(input int sel);
    return (sel == 0) ? 32'(ovf0) : (sel == 1) ? 32'(ovf1) : 32'(ovf2);
  endfunction
  function automatic logic [31:0] get_hex(input int sel);
    return (sel == 0) ? 32'(hex0) : (sel == 1) ? 32'(hex1) : 32'(hex2);
  endfunction
  function automatic logic [31:0] get_oct(input int sel);
    return (sel == 0) ? 32'(oct0) : (sel == 1) ? 32'(oct1) : 32'(oct2);
  endfunction

  task automatic set_in(input int sel, input logic s, input logic [15:0] v);
    case (sel)
      0:       begin start0 = s; bin0 = v[7:0]; end
      1:       begin start1 = s; bin1 = v;      end
      default: begin start2 = s; bin2 = v[7:0]; end
    endcase
  endtask

  task automatic check_all_zero(input int sel, input string tag);
    check({tag, " busy"}, get_busy(sel), 0);
    check({tag, " done"}, get_done(sel), 0);
    check({tag, " bcd"},  get_bcd(sel),  0);
    check({tag, " ovf"},  get_ovf(sel),  0);
    check({tag, " hex"},  get_hex(sel),  0);
    check({tag, " oct"},  get_oct(sel),  0);
  endtask

  // One conversion; inject>0 pulses a stray start (operand 7) at that cycle of the run.
  task automatic convert(input int sel, input logic [15:0] val, input int inject, input string tag);
    int w, lat, extra_done;
    logic seen;
    logic [31:0] v, eb, eo;
    w  = width_of(sel);
    v  = 32'(val) & ((32'd1 << w) - 1);
    eb = ref_bcd(v, digits_of(sel));
    eo = ref_ovf(v, digits_of(sel));
    @(negedge clk);
    set_in(sel, 1'b1, v[15:0]);
    @(posedge clk); #1;
    check({tag, " busy@accept"}, get_busy(sel), 1);
    check({tag, " hex@accept"},  get_hex(sel),  v);
    @(negedge clk);
    set_in(sel, 1'b0, 16'($urandom));
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (get_done(sel) == 1) seen = 1'b1;
      if (get_busy(sel) != 1) check({tag, " busy during run"}, get_busy(sel), 1);
      if (inject > 0 && lat == inject) begin
        @(negedge clk); set_in(sel, 1'b1, 16'd7);
      end else if (inject > 0 && lat == inject + 1) begin
        @(negedge clk); set_in(sel, 1'b0, 16'($urandom));
      end
    end
    check({tag, " latency"},  32'(lat),      32'(w));
    check({tag, " bcd"},      get_bcd(sel),  eb);
    check({tag, " overflow"}, get_ovf(sel),  eo);
    check({tag, " hex"},      get_hex(sel),  v);
    check({tag, " oct"},      get_oct(sel),  v);
    @(posedge clk); #1;
    check({tag, " done pulse width"}, get_done(sel), 0);
    check({tag, " busy in idle"},     get_busy(sel), 0);
    if (inject > 0) begin
      extra_done = 0;
      for (int i = 0; i < w + 4; i++) begin
        @(posedge clk); #1;
        if (get_done(sel) == 1) extra_done++;
      end
      check({tag, " no second done"}, 32'(extra_done), 0);
      check({tag, " bcd held"},       get_bcd(sel),    eb);
    end
    $display("conv %s sel=%0d val=%0d lat=%0d bcd=%0h ovf=%0d", tag, sel, v, lat, get_bcd(sel), get_ovf(sel));
  endtask

  task automatic wait_done(input int sel, output int cycles);
    cycles = 0;
    do begin
      @(posedge clk); #1;
      cycles++;
    end while (get_done(sel) != 1 && cycles < 40);
  endtask

  initial begin
    int c1, c2;
    rst = 1'b1;
    set_in(0, 1'b0, 16'd0);
    set_in(1, 1'b0, 16'd0);
    set_in(2, 1'b0, 16'd0);
    repeat (3) @(negedge clk);
    check_all_zero(0, "reset dut0");
    check_all_zero(1, "reset dut1");
    check_all_zero(2, "reset dut2");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    convert(0, 16'hFF, 0, "w8 ff");
    convert(0, 16'd0,  0, "w8 zero");
    convert(0, 16'd99, 0, "w8 99");
    convert(0, 16'd200, 3, "w8 200 stray start");

    // Reset asserted between edges must clear everything at once.
    @(negedge clk);
    set_in(0, 1'b1, 16'd123);
    @(negedge clk);
    set_in(0, 1'b0, 16'd0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_all_zero(0, "async abort");
    @(negedge clk);
    rst = 1'b0;
    convert(0, 16'd42, 0, "w8 42 after abort");

    convert(1, 16'hFFFF, 0, "w16 ffff");
    convert(2, 16'd200, 0, "w8d2 200");
    convert(2, 16'd57,  0, "w8d2 57");

    // Start held high: back-to-back conversions every WIDTH+2 cycles.
    @(negedge clk);
    set_in(0, 1'b1, 16'd123);
    wait_done(0, c1);
    wait_done(0, c2);
    check("back-to-back period", 32'(c2), 32'd10);
    check("back-to-back bcd",    get_bcd(0), 32'h123);
    $display("conv back-to-back sel=0 val=123 period=%0d bcd=%0h", c2, get_bcd(0));
    @(negedge clk);
    set_in(0, 1'b0, 16'd0);
    repeat (3) @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      for (int s = 0; s < 3; s++) begin
        convert(s, 16'($urandom), 0, "random");
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/binary_to_bcd_seq.md
Name: binary_to_bcd_seq

Overview:
Parametrised, sequential successor to the team's combinational binary converter. Converts a WIDTH-bit unsigned binary word to packed BCD with an iterative shift-add-3 (double-dabble) engine, one bit per clock. It also presents zero-extended hex-nibble and octal-digit views of the captured operand. The block sits between a binary producer and display/UART formatting logic, using a start/busy/done handshake.

Parameters:
- WIDTH, 8, binary input width (≥2).
- DIGITS, 3, number of BCD output digits. Sized ceil(WIDTH*0.30103) for lossless conversion; smaller values are legal and set overflow.
- HEXW, 4*ceil(WIDTH/4), derived (localparam), hex output width.
- OCTW, 3*ceil(WIDTH/3), derived (localparam), octal output width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request a conversion; sampled only in IDLE.
- bin_in  in  WIDTH  operand; captured on the clock edge that accepts start.
- busy  out  1  high from the accept edge until done deasserts.
- done  out  1  single-cycle pulse; results are valid from this cycle on.
- bcd_out  out  4*DIGITS  packed BCD, digit 0 in bits [3:0].
- overflow  out  1  a nonzero carry was lost out of the top digit.
- hex_out  out  HEXW  captured operand, zero-extended to whole nibbles.
- oct_out  out  OCTW  captured operand, zero-extended to whole 3-bit digits.

Behaviour:
- Reset (async, immediate): state=IDLE; busy, done, overflow=0; bcd_out, hex_out, oct_out=0; internal shift register and counter=0.
- States: IDLE, SHIFT, DONE.
- IDLE: on an edge with start=1, load shift_reg←bin_in, scratch BCD←0, count←WIDTH, hex_out/oct_out←zero-extended bin_in; go to SHIFT; busy=1 from the next cycle.
- SHIFT, each edge:
  - Every scratch digit ≥5 gets +3 (combinational, via sub-module).
  - Then {scratch, shift_reg} shifts left by 1.
  - Any 1 shifted out of the top digit sets a sticky overflow accumulator.
  - count decrements.
  - On the edge where count goes 1→0: bcd_out←final scratch, overflow←accumulator, go to DONE.
- DONE: done=1, busy=1 for exactly one cycle; next edge → IDLE, busy=0.
- Latency: start accepted at edge E0 → done high in the cycle following edge E_WIDTH (WIDTH clocks). Throughput is one conversion per WIDTH+2 cycles.
- start while busy (SHIFT or DONE) is ignored, not queued.
- start held high continuously gives back-to-back conversions: accepted again in IDLE.
- bcd_out, overflow, hex_out and oct_out hold their values until the next completed conversion or reset. Exception: hex_out and oct_out update at accept, not at done.
- Reset mid-conversion aborts immediately to the reset values; there is no partial result.
- Out-of-range DIGITS: bcd_out is the value mod 10^DIGITS; overflow=1 whenever the true value ≥10^DIGITS.
- All arithmetic is unsigned; no X propagation from bin_in outside the accept edge.

Decomposition:
- Package bin_conv_pkg:
  - state enum (IDLE, SHIFT, DONE);
  - function clog10_digits(width) giving the default DIGITS;
  - localparams BCD_ADJ_THRESH=5 and BCD_ADJ_ADD=3.
- Sub-module bcd_digit_adj: purely combinational, 4-bit in → 4-bit out (adds 3 if ≥5). Instantiated DIGITS times via generate.
- The top holds the FSM, counter and shift register.

Test Plan:
- WIDTH=8, DIGITS=3, bin_in=8'hFF, one-cycle start → done exactly 8 clocks after the accept edge; bcd_out=12'h255, overflow=0, hex_out=8'hFF, oct_out=9'o377.
- bin_in=0 → bcd_out=12'h000, done after 8 clocks. Then bin_in=8'd99 → 12'h099. busy is high throughout each conversion and low for at least one IDLE cycle between them.
- During a conversion of 8'd200, pulse start with bin_in=8'd7 at cycle 3 → ignored; result is 12'h200 and no second done.
- Assert rst at cycle 4 of a conversion → all outputs 0 immediately. After release, a start with 8'd42 → 12'h042.
- WIDTH=16, DIGITS=5, bin_in=16'hFFFF → bcd_out=20'h65535 after 16 clocks, hex_out=16'hFFFF, oct_out=18'o177777.
- WIDTH=8, DIGITS=2, bin_in=8'd200 → bcd_out=8'h00, overflow=1. Next conversion of 8'd57 → 8'h57, overflow=0.
